// File: rtl/neuro_pkg.sv
// neuro_pkg: shared defaults, tile-store state encoding and tile index helper
package neuro_pkg;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_J = 2;
  localparam int DEF_K = 2;
  localparam int DEF_ADDR_W = 10;
  typedef enum logic [1:0] {IDLE, ISSUE, MERGE, DONE} state_e;
  function automatic int tile_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction
endpackage

// File: rtl/block_addr_gen.sv
// block_addr_gen: maps a row-major tile element index to a matrix address and bounds flag
module block_addr_gen
  import neuro_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int K = DEF_K,
  parameter int EW = 2
) (
  input  logic [ADDR_W-1:0] start_row_i,
  input  logic [ADDR_W-1:0] start_col_i,
  input  logic [EW-1:0]     elem_i,
  input  logic [ADDR_W-1:0] mat_cols_i,
  input  logic [ADDR_W-1:0] mat_rows_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              in_bounds_o
);
  logic [ADDR_W:0] row, col;
  logic [2*ADDR_W-1:0] prod;
  assign row = (ADDR_W+1)'(start_row_i) + (ADDR_W+1)'(32'(elem_i) / K);
  assign col = (ADDR_W+1)'(start_col_i) + (ADDR_W+1)'(32'(elem_i) % K);
  assign prod = (2*ADDR_W)'(row[ADDR_W-1:0]) * (2*ADDR_W)'(mat_cols_i);
  assign addr_o = ADDR_W'(prod) + col[ADDR_W-1:0];
  assign in_bounds_o = (row < (ADDR_W+1)'(mat_rows_i)) && (col < (ADDR_W+1)'(mat_cols_i));
endmodule

// File: rtl/block_store.sv
// block_store: writes or accumulates a J x K tile into a row-major matrix memory
module block_store
  import neuro_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int J = DEF_J,
  parameter int K = DEF_K,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     start_row,
  input  logic [ADDR_W-1:0]     start_col,
  input  logic [ADDR_W-1:0]     mat_rows,
  input  logic [ADDR_W-1:0]     mat_cols,
  input  logic                  accumulate,
  input  logic [J*K*DATA_W-1:0] tile,
  output logic                  rd_en,
  output logic [ADDR_W-1:0]     rd_addr,
  input  logic [DATA_W-1:0]     rd_data,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  done
);
  localparam int N = J * K;
  localparam int EW = N > 1 ? $clog2(N) : 1;
  state_e state_q, state_d;
  logic start_q;
  logic [EW-1:0] elem_q, elem_d;
  logic [ADDR_W-1:0] row_q, row_d, col_q, col_d, rows_q, rows_d, cols_q, cols_d;
  logic acc_q, acc_d;
  logic [N*DATA_W-1:0] tile_q, tile_d;
  logic rd_en_q, rd_en_d, wr_en_q, wr_en_d, merge_q, merge_d, busy_q, busy_d, done_q, done_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, addr;
  logic [DATA_W-1:0] wdat_q, wdat_d, cur;
  logic in_bounds, last;

  block_addr_gen #(.ADDR_W(ADDR_W), .K(K), .EW(EW)) u_addr (
    .start_row_i(row_q),
    .start_col_i(col_q),
    .elem_i(elem_q),
    .mat_cols_i(cols_q),
    .mat_rows_i(rows_q),
    .addr_o(addr),
    .in_bounds_o(in_bounds)
  );

  assign cur = tile_q[elem_q*DATA_W +: DATA_W];
  assign last = elem_q == EW'(N - 1);
  assign rd_en = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = merge_q ? rd_data + wdat_q : wdat_q;
  assign busy = busy_q;
  assign done = done_q;

  // next state: capture in IDLE, issue a write or read per element, merge read data, pulse done
  always_comb begin
    state_d = state_q;
    elem_d = elem_q;
    row_d = row_q;
    col_d = col_q;
    rows_d = rows_q;
    cols_d = cols_q;
    acc_d = acc_q;
    tile_d = tile_q;
    rd_en_d = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_en_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wdat_d = wdat_q;
    merge_d = 1'b0;
    done_d = 1'b0;
    busy_d = state_q == ISSUE || state_q == MERGE;
    case (state_q)
      IDLE: if (start && !start_q) begin
        row_d = start_row;
        col_d = start_col;
        rows_d = mat_rows;
        cols_d = mat_cols;
        acc_d = accumulate;
        tile_d = tile;
        elem_d = '0;
        state_d = ISSUE;
      end
      ISSUE: if (in_bounds && acc_q) begin
        rd_en_d = 1'b1;
        rd_addr_d = addr;
        state_d = MERGE;
      end else begin
        wr_en_d = in_bounds;
        wr_addr_d = in_bounds ? addr : wr_addr_q;
        wdat_d = in_bounds ? cur : wdat_q;
        elem_d = elem_q + EW'(1);
        state_d = last ? DONE : ISSUE;
      end
      MERGE: begin
        wr_en_d = 1'b1;
        wr_addr_d = rd_addr_q;
        wdat_d = cur;
        merge_d = 1'b1;
        elem_d = elem_q + EW'(1);
        state_d = last ? DONE : ISSUE;
      end
      default: begin
        done_d = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // state and registered outputs; reset aborts any operation at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      elem_q <= '0;
      row_q <= '0;
      col_q <= '0;
      rows_q <= '0;
      cols_q <= '0;
      acc_q <= 1'b0;
      tile_q <= '0;
      rd_en_q <= 1'b0;
      rd_addr_q <= '0;
      wr_en_q <= 1'b0;
      wr_addr_q <= '0;
      wdat_q <= '0;
      merge_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      elem_q <= elem_d;
      row_q <= row_d;
      col_q <= col_d;
      rows_q <= rows_d;
      cols_q <= cols_d;
      acc_q <= acc_d;
      tile_q <= tile_d;
      rd_en_q <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      wr_en_q <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wdat_q <= wdat_d;
      merge_q <= merge_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
